// File: rtl/decoder_seq.sv
// decoder_seq: M-cycle sequencer in front of the SM83 decoder PLA.
// Holds the current opcode, the CB-prefix flag, the M-cycle index and the
// RUN / HALT / INT execution mode. It presents these to the decoder as a
// 26-bit dual-rail vector.
// The decoder answers with SEQ_LAST, which closes the instruction, and
// with HALT_OP on the last M-cycle of a HALT.
module decoder_seq #(
    parameter int MC_MAX = 7,   // highest legal M-cycle index
    parameter int INT_MC = 5,   // M-cycles in interrupt dispatch (1..INT_MC)
    parameter int ACK_MC = 3    // dispatch M-cycle whose step raises INT_ACK
) (
    input  logic        i_clk2,
    input  logic        i_nreset,
    input  logic        i_adv,
    input  logic        i_wait,
    input  logic        i_seq_last,
    input  logic        i_halt_op,
    input  logic [7:0]  i_din,
    input  logic        i_int_req,
    input  logic        i_ime,
    output logic [25:0] o_a,
    output logic [7:0]  o_ir,
    output logic [2:0]  o_mcyc,
    output logic        o_cb,
    output logic        o_in_int,
    output logic        o_halted,
    output logic        o_int_ack,
    output logic        o_seq_err
);

    localparam logic [2:0] MC_MAX_V = 3'(MC_MAX);
    localparam logic [2:0] INT_MC_V = 3'(INT_MC);
    localparam logic [2:0] ACK_MC_V = 3'(ACK_MC);
    localparam logic [7:0] OP_CB    = 8'hCB;
    localparam logic [7:0] OP_NOP   = 8'h00;

    // RUN also covers the post-reset fetch: MCYC=0 with IR=00 is a NOP fetch.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_INT  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_ir;
    logic [7:0]  w_ir_next;
    logic [2:0]  r_mcyc;
    logic [2:0]  w_mcyc_next;
    logic        r_cb;
    logic        w_cb_next;
    logic        r_seq_err;
    logic        w_seq_err_next;
    logic        r_int_ack;
    logic        w_int_ack_next;

    logic        w_step;
    logic        w_int_take;
    logic        w_cb_on_latch;
    logic        w_in_int;
    logic [12:0] w_sig;

    // An ADV that arrives during WAIT is dropped, not queued.
    assign w_step     = i_adv & ~i_wait;
    assign w_int_take = i_int_req & i_ime;

    // CB flag of the next latched opcode. It is set only when the
    // instruction now closing is the CB prefix itself, and that prefix was
    // a plain opcode (CB=0). A CB-table opcode that happens to be CB
    // therefore does not chain into another prefix.
    assign w_cb_on_latch = ~r_cb & (r_ir == OP_CB);

    // State register. Reset discards everything, including the sticky error.
    always_ff @(posedge i_clk2 or negedge i_nreset) begin
        if (!i_nreset) begin
            r_state   <= ST_RUN;
            r_ir      <= OP_NOP;
            r_mcyc    <= 3'd0;
            r_cb      <= 1'b0;
            r_seq_err <= 1'b0;
            r_int_ack <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_ir      <= w_ir_next;
            r_mcyc    <= w_mcyc_next;
            r_cb      <= w_cb_next;
            r_seq_err <= w_seq_err_next;
            r_int_ack <= w_int_ack_next;
        end
    end

    // Next-state logic. Everything holds except on a step. INT_ACK is the
    // exception: it defaults low, so it lasts a single cycle.
    always_comb begin
        w_state_next   = r_state;
        w_ir_next      = r_ir;
        w_mcyc_next    = r_mcyc;
        w_cb_next      = r_cb;
        w_seq_err_next = r_seq_err;
        w_int_ack_next = 1'b0;

        if (w_step) begin
            unique case (r_state)
                ST_RUN: begin
                    if (!i_seq_last) begin
                        // Mid-instruction. Running past the last legal
                        // index means the decoder never closed the
                        // instruction: pin the counter and flag it.
                        if (r_mcyc == MC_MAX_V) begin
                            w_seq_err_next = 1'b1;
                        end else begin
                            w_mcyc_next = r_mcyc + 3'd1;
                        end
                    end else if (w_int_take) begin
                        // A pending interrupt wins over the next opcode.
                        // Dispatch counts its M-cycles from 1.
                        w_state_next = ST_INT;
                        w_ir_next    = OP_NOP;
                        w_cb_next    = 1'b0;
                        w_mcyc_next  = 3'd1;
                    end else if (i_halt_op) begin
                        // IR keeps the HALT opcode while halted.
                        w_state_next = ST_HALT;
                        w_mcyc_next  = 3'd0;
                    end else begin
                        // Fetch overlap: the byte on DIN during the last
                        // step is the next opcode.
                        w_ir_next   = i_din;
                        w_mcyc_next = 3'd0;
                        w_cb_next   = w_cb_on_latch;
                    end
                end

                ST_HALT: begin
                    // SEQ_LAST and HALT_OP mean nothing here.
                    // Only a pending request ends the halt.
                    if (i_int_req) begin
                        if (i_ime) begin
                            w_state_next = ST_INT;
                            w_ir_next    = OP_NOP;
                            w_cb_next    = 1'b0;
                            w_mcyc_next  = 3'd1;
                        end else begin
                            // Wake without dispatch. The opcode after HALT
                            // is fetched normally. The HALT bug (PC not
                            // advancing) is not reproduced.
                            w_state_next = ST_RUN;
                            w_ir_next    = i_din;
                            w_mcyc_next  = 3'd0;
                            w_cb_next    = w_cb_on_latch;
                        end
                    end
                end

                ST_INT: begin
                    // The ACK M-cycle is the vector read. The pulse tells
                    // the interrupt block to clear the IF bit and IME.
                    if (r_mcyc == ACK_MC_V) begin
                        w_int_ack_next = 1'b1;
                    end
                    if (r_mcyc < INT_MC_V) begin
                        w_mcyc_next = r_mcyc + 3'd1;
                    end else begin
                        // Last dispatch M-cycle doubles as the fetch of the
                        // handler's first opcode.
                        w_state_next = ST_RUN;
                        w_ir_next    = i_din;
                        w_mcyc_next  = 3'd0;
                        w_cb_next    = 1'b0;
                    end
                end

                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

    assign w_in_int = (r_state == ST_INT);

    // Decoder signal order, LSB first: IN_INT, CB, IR[0..7], MCYC[0..2].
    assign w_sig = {r_mcyc, r_ir, r_cb, w_in_int};

    // Dual-rail expansion. Each signal drives a true rail and a complement
    // rail, so every PLA product term sees both polarities.
    generate
        for (genvar gi = 0; gi < 13; gi++) begin : g_rail
            assign o_a[2*gi]     = w_sig[gi];
            assign o_a[2*gi + 1] = ~w_sig[gi];
        end
    endgenerate

    assign o_ir      = r_ir;
    assign o_mcyc    = r_mcyc;
    assign o_cb      = r_cb;
    assign o_in_int  = w_in_int;
    assign o_halted  = (r_state == ST_HALT);
    assign o_int_ack = r_int_ack;
    assign o_seq_err = r_seq_err;

endmodule

// File: tb/tb_decoder_seq.sv
// Testbench for decoder_seq: directed scenarios plus a random run.
// Expected values come from a step-level reference model written from the
// sequencer's behavioural rules.
module tb_decoder_seq;

    logic        i_clk2 = 1'b0;
    logic        i_nreset = 1'b0;
    logic        i_adv = 1'b0;
    logic        i_wait = 1'b0;
    logic        i_seq_last = 1'b0;
    logic        i_halt_op = 1'b0;
    logic [7:0]  i_din = 8'h00;
    logic        i_int_req = 1'b0;
    logic        i_ime = 1'b0;
    logic [25:0] o_a;
    logic [7:0]  o_ir;
    logic [2:0]  o_mcyc;
    logic        o_cb;
    logic        o_in_int;
    logic        o_halted;
    logic        o_int_ack;
    logic        o_seq_err;

    int errors = 0;
    int checks = 0;

    decoder_seq dut (
        .i_clk2     (i_clk2),
        .i_nreset   (i_nreset),
        .i_adv      (i_adv),
        .i_wait     (i_wait),
        .i_seq_last (i_seq_last),
        .i_halt_op  (i_halt_op),
        .i_din      (i_din),
        .i_int_req  (i_int_req),
        .i_ime      (i_ime),
        .o_a        (o_a),
        .o_ir       (o_ir),
        .o_mcyc     (o_mcyc),
        .o_cb       (o_cb),
        .o_in_int   (o_in_int),
        .o_halted   (o_halted),
        .o_int_ack  (o_int_ack),
        .o_seq_err  (o_seq_err)
    );

    always #5 i_clk2 = ~i_clk2;

    // Reference model. Mode: 0 = run, 1 = halted, 2 = interrupt dispatch.
    int         m_mode;
    logic [7:0] m_ir;
    int         m_mcyc;
    bit         m_cb;
    bit         m_err;
    bit         m_ack;
    bit         m_prefix_pending;  // the instruction now executing is a plain CB prefix

    wire [41:0] dut_vec = {o_a, o_ir, o_mcyc, o_cb, o_in_int, o_halted, o_int_ack, o_seq_err};

    function automatic void model_reset();
        m_mode = 0; m_ir = 8'h00; m_mcyc = 0; m_cb = 0; m_err = 0; m_ack = 0;
        m_prefix_pending = 0;
    endfunction

    // A new opcode starts; it is CB-table only if the instruction just
    // finished was a bare CB prefix.
    function automatic void model_new_opcode(input logic [7:0] op);
        m_cb = m_prefix_pending;
        m_prefix_pending = (op == 8'hCB) && !m_cb;
        m_ir = op;
        m_mcyc = 0;
    endfunction

    function automatic void model_enter_int();
        m_mode = 2; m_ir = 8'h00; m_cb = 0; m_mcyc = 1; m_prefix_pending = 0;
    endfunction

    function automatic void model_step(input bit adv, wt, sl, hop, input logic [7:0] din,
                                       input bit req, ime);
        m_ack = 0;
        if (!(adv && !wt)) return;
        if (m_mode == 0) begin
            if (!sl) begin
                if (m_mcyc == 7) m_err = 1;
                else m_mcyc = m_mcyc + 1;
            end else if (req && ime) begin
                model_enter_int();
            end else if (hop) begin
                m_mode = 1; m_mcyc = 0;
            end else begin
                model_new_opcode(din);
            end
        end else if (m_mode == 1) begin
            if (req && ime) model_enter_int();
            else if (req) begin
                m_mode = 0;
                model_new_opcode(din);
            end
        end else begin
            if (m_mcyc == 3) m_ack = 1;
            if (m_mcyc < 5) m_mcyc = m_mcyc + 1;
            else begin
                m_mode = 0; m_ir = din; m_mcyc = 0; m_cb = 0; m_prefix_pending = (din == 8'hCB);
            end
        end
    endfunction

    function automatic logic [41:0] exp_vec();
        logic [12:0] s;
        logic [25:0] a;
        s = {3'(m_mcyc), m_ir, m_cb, (m_mode == 2)};
        for (int k = 0; k < 13; k++) begin
            a[2*k]     = s[k];
            a[2*k + 1] = ~s[k];
        end
        return {a, m_ir, 3'(m_mcyc), m_cb, (m_mode == 2), (m_mode == 1), m_ack, m_err};
    endfunction

    // Drive one CLK2 cycle of inputs; the model follows the same edge.
    task automatic cyc(input bit adv, wt, sl, hop, input logic [7:0] din, input bit req, ime);
        i_adv = adv; i_wait = wt; i_seq_last = sl; i_halt_op = hop;
        i_din = din; i_int_req = req; i_ime = ime;
        @(posedge i_clk2);
        if (!i_nreset) model_reset();
        else model_step(adv, wt, sl, hop, din, req, ime);
        #1;
    endtask

    task automatic test_reset();
        i_nreset = 1'b0;
        #2;
        model_reset();
        checks++;
        if (o_a !== 26'h2AAAAAA) begin
            errors++; $display("FAIL reset_a got=%h exp=%h", o_a, 26'h2AAAAAA);
        end
        checks++;
        if ({o_ir, o_mcyc, o_cb, o_in_int, o_halted, o_int_ack, o_seq_err} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_flags got=%h exp=0000",
                     {o_ir, o_mcyc, o_cb, o_in_int, o_halted, o_int_ack, o_seq_err});
        end
        cyc(0, 0, 0, 0, 8'h00, 0, 0);
        i_nreset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 8'h3E, 1, 1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL reset_idle got=%h exp=%h", dut_vec, exp_vec());
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_three_cycle();
        logic [2:0] exp_m [3] = '{3'd1, 3'd2, 3'd0};
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, (i == 2), 0, 8'h3E, 0, 0);
            checks++;
            if (o_mcyc !== exp_m[i] || dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL three_cycle step%0d mcyc got=%0d exp=%0d vec got=%h exp=%h",
                         i, o_mcyc, exp_m[i], dut_vec, exp_vec());
            end
        end
        checks++;
        if (o_ir !== 8'h3E || o_cb !== 1'b0) begin
            errors++; $display("FAIL three_cycle_ir got=%h/%b exp=3e/0", o_ir, o_cb);
        end
        $display("test_three_cycle done");
    endtask

    task automatic test_cb_prefix();
        logic [7:0] ops [3] = '{8'hCB, 8'h37, 8'h00};
        logic       cbs [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1, 0, ops[i], 0, 0);
            checks++;
            if (o_ir !== ops[i] || o_cb !== cbs[i] || dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL cb_prefix step%0d ir/cb got=%h/%b exp=%h/%b", i, o_ir, o_cb, ops[i], cbs[i]);
            end
        end
        $display("test_cb_prefix done");
    endtask

    task automatic test_interrupt();
        int acks = 0;
        cyc(1, 0, 1, 0, 8'h77, 1, 1);
        checks++;
        if (o_in_int !== 1'b1 || o_mcyc !== 3'd1 || o_ir !== 8'h00) begin
            errors++; $display("FAIL int_entry in_int/mcyc/ir got=%b/%0d/%h exp=1/1/00", o_in_int, o_mcyc, o_ir);
        end
        for (int i = 0; i < 5; i++) begin
            // SEQ_LAST and HALT_OP are random here: they must be ignored.
            cyc(1, 0, 1'($urandom), 1'($urandom), 8'h5A, 1'($urandom), 1'($urandom));
            if (o_int_ack) acks++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL int_step%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            cyc(0, 0, 0, 0, 8'h00, 0, 0);
            if (o_int_ack) acks++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL int_idle%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (acks != 1 || o_in_int !== 1'b0 || o_ir !== 8'h5A || o_mcyc !== 3'd0) begin
            errors++;
            $display("FAIL int_exit acks/in_int/ir got=%0d/%b/%h exp=1/0/5a", acks, o_in_int, o_ir);
        end
        $display("test_interrupt done");
    endtask

    task automatic test_halt();
        cyc(1, 0, 1, 1, 8'h11, 0, 0);
        checks++;
        if (o_halted !== 1'b1 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL halt_entry halted got=%b exp=1", o_halted);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 1'($urandom), 1'($urandom), 8'($urandom), 0, 1'($urandom));
            checks++;
            if (o_halted !== 1'b1 || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL halt_hold%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        cyc(1, 0, 0, 0, 8'h21, 1, 0);
        checks++;
        if (o_halted !== 1'b0 || o_ir !== 8'h21 || o_int_ack !== 1'b0 || o_in_int !== 1'b0) begin
            errors++;
            $display("FAIL halt_wake halted/ir/ack got=%b/%h/%b exp=0/21/0", o_halted, o_ir, o_int_ack);
        end
        $display("test_halt done");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 8'h00, 0, 0);
        checks++;
        if (o_mcyc !== 3'd7 || o_seq_err !== 1'b1 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL overflow mcyc/err got=%0d/%b exp=7/1", o_mcyc, o_seq_err);
        end
        cyc(1, 0, 1, 0, 8'h00, 0, 0);
        checks++;
        if (o_seq_err !== 1'b1 || o_mcyc !== 3'd0) begin
            errors++; $display("FAIL overflow_sticky err/mcyc got=%b/%0d exp=1/0", o_seq_err, o_mcyc);
        end
        $display("test_overflow done");
    endtask

    task automatic test_wait();
        cyc(1, 0, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 1'($urandom), 0, 8'($urandom), 1, 1);
            checks++;
            if (o_mcyc !== 3'd1 || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL wait_hold%0d mcyc got=%0d exp=1", i, o_mcyc);
            end
        end
        cyc(1, 0, 1, 0, 8'h06, 0, 0);
        checks++;
        if (o_ir !== 8'h06 || o_mcyc !== 3'd0) begin
            errors++; $display("FAIL wait_resume ir/mcyc got=%h/%0d exp=06/0", o_ir, o_mcyc);
        end
        $display("test_wait done");
    endtask

    task automatic test_reset_mid_int();
        cyc(1, 0, 1, 0, 8'h00, 1, 1);
        cyc(1, 0, 0, 0, 8'h00, 0, 0);
        checks++;
        if (o_in_int !== 1'b1 || o_mcyc !== 3'd2) begin
            errors++; $display("FAIL midint_setup in_int/mcyc got=%b/%0d exp=1/2", o_in_int, o_mcyc);
        end
        i_nreset = 1'b0;
        #2;
        model_reset();
        checks++;
        if (o_a !== 26'h2AAAAAA || o_in_int !== 1'b0 || o_seq_err !== 1'b0 || o_mcyc !== 3'd0) begin
            errors++; $display("FAIL midint_reset a/err got=%h/%b exp=2aaaaaa/0", o_a, o_seq_err);
        end
        cyc(1, 0, 1, 0, 8'h3E, 1, 1);
        i_nreset = 1'b1;
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL midint_held got=%h exp=%h", dut_vec, exp_vec());
        end
        $display("test_reset_mid_int done");
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 20),
                ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 10),
                ($urandom_range(0, 99) < 20) ? 8'hCB : 8'($urandom),
                ($urandom_range(0, 99) < 15), 1'($urandom));
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                if (bad < 10) $display("FAIL random cyc%0d got=%h exp=%h", i, dut_vec, exp_vec());
                bad++;
            end
        end
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_three_cycle();
        test_cb_prefix();
        test_interrupt();
        test_halt();
        test_overflow();
        test_wait();
        test_reset_mid_int();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
